seq_pattern_detect: RTL and testbench

Parametrised serial bit-pattern detector. It replaces the fixed 4-bit "1001" detector with a runtime-programmable pattern of 1..MAX_LEN bits, a selectable overlap/non-overlap mode, an input-valid qualifier and a saturating match counter. It sits on a serial bit stream, for example a deserialiser output or a sync-word hunt, and flags each occurrence of the pattern.

---
 rtl/seq_pattern_detect.sv | 89 ++++++++
 tb/tb_seq_pattern_detect.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detect.sv
// Serial bit-pattern detector: programmable 1..MAX_LEN pattern, overlap mode, saturating match counter.
// Latency: seq_seen pulses the cycle after the matching bit's edge; no backpressure, one bit per valid cycle.
module seq_pattern_detect #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1001),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic [LEN_W-1:0]   cur_len
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN:0]   mask_full;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic               hit;
    logic               cfg_ok;

    // fill < len is the FILLING phase; once fill+1 reaches len every valid bit is compared (HUNTING).
    always_comb begin
        hist_nxt  = {hist_q[MAX_LEN-2:0], in_bit};
        mask_full = ((MAX_LEN + 1)'(1) << len_q) - (MAX_LEN + 1)'(1);
        mask      = mask_full[MAX_LEN-1:0];
        fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_sat  = (fill_inc > (LEN_W + 1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_inc[LEN_W-1:0];
        hit       = (fill_inc >= {1'b0, len_q}) && ((hist_nxt & mask) == (pattern_q & mask));
        cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= DEF_PATTERN;
            len_q       <= LEN_W'(DEF_LEN);
            overlap_q   <= DEF_OVERLAP;
            hist_q      <= '0;
            fill_q      <= '0;
            match_count <= '0;
            seq_seen    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            seq_seen <= 1'b0;
            cfg_err  <= 1'b0;
            if (cfg_load) begin
                // The bit presented alongside a load is dropped whether or not the load is accepted.
                if (cfg_ok) begin
                    pattern_q   <= cfg_pattern;
                    len_q       <= cfg_len;
                    overlap_q   <= cfg_overlap;
                    hist_q      <= '0;
                    fill_q      <= '0;
                    match_count <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (in_valid) begin
                hist_q <= hist_nxt;
                fill_q <= (hit && !overlap_q) ? '0 : fill_sat;
                if (hit) begin
                    seq_seen <= 1'b1;
                    if (match_count != '1)
                        match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end

    assign cur_len = len_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed-vector bench: driver queues hand-computed per-cycle expectations, a monitor pops and compares.
module tb_seq_pattern_detect;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       seq_seen;
    logic [1:0] match_count;
    logic       cfg_err;
    logic [3:0] cur_len;

    typedef struct {
        logic       seen;
        logic [1:0] cnt;
        logic       err;
        logic [3:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   vec = 0;
    bit   drive_done = 1'b0;

    seq_pattern_detect #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .seq_seen(seq_seen), .match_count(match_count), .cfg_err(cfg_err), .cur_len(cur_len)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic ld, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic v, input logic b, input logic es,
                        input logic [1:0] ec, input logic ee, input logic [3:0] el);
        exp_t e;
        @(negedge clk);
        reset = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
        in_valid = v; in_bit = b;
        e.seen = es; e.cnt = ec; e.err = ee; e.len = el;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4);
    endtask

    task automatic bit_in(input logic v, input logic b, input logic es, input logic [1:0] ec,
                          input logic [3:0] el);
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, b, es, ec, 1'b0, el);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic v,
                       input logic b, input logic ee, input logic [1:0] ec, input logic [3:0] el);
        step(1'b0, 1'b1, p, l, ov, v, b, 1'b0, ec, ee, el);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, vec, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("seq_seen", int'(seq_seen), int'(e.seen));
                check("match_count", int'(match_count), int'(e.cnt));
                check("cfg_err", int'(cfg_err), int'(e.err));
                check("cur_len", int'(cur_len), int'(e.len));
                vec++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: drive_done %0d expected 1", drive_done);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        do_reset();

        // Default 1001 non-overlap: 1,0,0,1,0,0,1 -> one pulse after bit 4
        bit_in(1, 1, 0, 0, 4); bit_in(1, 0, 0, 0, 4); bit_in(1, 0, 0, 0, 4);
        bit_in(1, 1, 1, 1, 4); bit_in(1, 0, 0, 1, 4); bit_in(1, 0, 0, 1, 4);
        bit_in(1, 1, 0, 1, 4);

        // Overlap 1001: pulses after bits 4 and 7
        cfg(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4);
        bit_in(1, 1, 0, 0, 4); bit_in(1, 0, 0, 0, 4); bit_in(1, 0, 0, 0, 4);
        bit_in(1, 1, 1, 1, 4); bit_in(1, 0, 0, 1, 4); bit_in(1, 0, 0, 1, 4);
        bit_in(1, 1, 1, 2, 4);

        // 101 non-overlap: 1,0,1,0,1,1,0,1 -> pulses after bits 3 and 8
        cfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3);
        bit_in(1, 1, 0, 0, 3); bit_in(1, 0, 0, 0, 3); bit_in(1, 1, 1, 1, 3);
        bit_in(1, 0, 0, 1, 3); bit_in(1, 1, 0, 1, 3); bit_in(1, 1, 0, 1, 3);
        bit_in(1, 0, 0, 1, 3); bit_in(1, 1, 1, 2, 3);

        // Rejected loads (len 0 and MAX_LEN+1); concurrent valid bits are dropped
        cfg(8'hFF, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'd3);
        bit_in(0, 0, 0, 2, 3);
        cfg(8'h55, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd3);

        // Prior pattern still active; in_valid toggling 1,0,... on 1,0,1
        bit_in(1, 1, 0, 2, 3); bit_in(0, 0, 0, 2, 3); bit_in(1, 0, 0, 2, 3);
        bit_in(0, 1, 0, 2, 3); bit_in(1, 1, 1, 3, 3); bit_in(0, 0, 0, 3, 3);

        // len=1 pattern=1 with a 2-bit counter: six pulses, count holds at 3
        cfg(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1);
        for (int i = 0; i < 6; i++)
            bit_in(1, 1, 1, (i < 3) ? 2'(i + 1) : 2'd3, 1);
        bit_in(1, 0, 0, 3, 1);

        // Reset discards partial 1,0,0 and restores the default config
        do_reset();
        bit_in(1, 1, 0, 0, 4); bit_in(1, 0, 0, 0, 4); bit_in(1, 0, 0, 0, 4);
        do_reset();
        bit_in(1, 1, 0, 0, 4); bit_in(1, 0, 0, 0, 4); bit_in(1, 0, 0, 0, 4);
        bit_in(1, 1, 1, 1, 4);

        // Bit alongside an accepted load is ignored: 11 needs two fresh bits
        cfg(8'b11, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd2);
        bit_in(1, 1, 0, 0, 2); bit_in(1, 1, 1, 1, 2);
        bit_in(0, 0, 0, 1, 2);

        drive_done = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
